// File: rtl/main_mem_pkg.sv
// Shared types and widths for the main data RAM arbiter and its requesters.
package main_mem_pkg;

   localparam int unsigned MEM_ADDR_W = 12;
   localparam int unsigned MEM_DATA_W = 16;
   localparam int unsigned STARVE_W   = 4;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_id_t;

   typedef struct packed {
      logic                  wren;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/main_mem_prio.sv
// Fixed-priority grant (port 0 first) with a saturating starvation counter
// that hands one contested cycle to port 1 after STARVE_LIMIT losses.
module main_mem_prio
   import main_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic n_reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0_c,
   output logic gnt1_c
);

   logic [STARVE_W-1:0] starve_cnt;
   logic                p1_turn_c;

   always_comb begin
      gnt0_c    = 1'b0;
      gnt1_c    = 1'b0;
      p1_turn_c = (starve_cnt == STARVE_W'(STARVE_LIMIT));
      if (req0 && req1) begin
         if (p1_turn_c) gnt1_c = 1'b1;
         else           gnt0_c = 1'b1;
      end else begin
         gnt0_c = req0;
         gnt1_c = req1;
      end
   end

   // Counts contested cycles lost by port 1; any port-1 grant clears it.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         starve_cnt <= '0;
      end else if (gnt1_c) begin
         starve_cnt <= '0;
      end else if (req0 && req1 && gnt0_c && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// Two-port pipelined arbiter for the single-port main RAM (drive + response stage).
// Optional conflict statistics enabled by defining MAIN_ARB_STATS_EN.
module main_mem_arbiter
   import main_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = MEM_ADDR_W,
   parameter int unsigned DATA_W       = MEM_DATA_W,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              p0_req,
   input  logic              p0_wren,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_wren,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_wren,
   input  logic [DATA_W-1:0] m_q,
   output logic              busy
`ifdef MAIN_ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [15:0]       conflict_cnt
`endif
);

   logic     d_valid;
   port_id_t d_port;

   main_mem_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clock   (clock),
      .n_reset (n_reset),
      .req0    (p0_req),
      .req1    (p1_req),
      .gnt0_c  (p0_gnt),
      .gnt1_c  (p1_gnt)
   );

   // Drive stage: present the winner to the RAM; write enable never lingers.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_addr  <= '0;
         m_data  <= '0;
         m_wren  <= 1'b0;
         d_valid <= 1'b0;
         d_port  <= PORT_CPU;
      end else begin
         d_valid <= p0_gnt | p1_gnt;
         m_wren  <= 1'b0;
         if (p0_gnt) begin
            m_addr <= p0_addr;
            m_data <= p0_wdata;
            m_wren <= p0_wren;
            d_port <= PORT_CPU;
         end else if (p1_gnt) begin
            m_addr <= p1_addr;
            m_data <= p1_wdata;
            m_wren <= p1_wren;
            d_port <= PORT_DBG;
         end
      end
   end

   // Response stage: capture read data and raise the done pulse of the owner.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         p0_done  <= 1'b0;
         p1_done  <= 1'b0;
         p0_rdata <= '0;
         p1_rdata <= '0;
         busy     <= 1'b0;
      end else begin
         p0_done <= d_valid && (d_port == PORT_CPU);
         p1_done <= d_valid && (d_port == PORT_DBG);
         busy    <= p0_gnt | p1_gnt | d_valid;
         if (d_valid && !m_wren) begin
            if (d_port == PORT_CPU) p0_rdata <= m_q;
            else                    p1_rdata <= m_q;
         end
      end
   end

`ifdef MAIN_ARB_STATS_EN
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         conflict_cnt <= '0;
      end else if (stats_clr) begin
         conflict_cnt <= '0;
      end else if (p0_req && p1_req && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule
